sram_bus_bridge: RTL and testbench

SRAM_BUS_BRIDGE -- requirements
Module: sram_bus_bridge

---
 rtl/sram_bus_bridge.sv | 130 +++++++++++++
 tb/tb_sram_bus_bridge.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_bridge.sv
// ============================================================================
//  Module   : sram_bus_bridge
//  Brief    : Valid/ready request bus to single-port synchronous SRAM bridge,
//             one outstanding transaction, address-window and alignment check.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sram_bus_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned READ_LAT  = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_we_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wmask_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        sram_csb_o,
    output logic        sram_we_o,
    output logic [12:0] sram_addr_o,
    output logic [31:0] sram_wdata_o,
    output logic [3:0]  sram_wmask_o,
    input  logic [31:0] sram_rdata_i
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_WAIT   = 2'd2;
    localparam logic [1:0] c_RESP   = 2'd3;
    localparam logic [2:0] c_LAST   = 3'(READ_LAT - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [2:0]  r_cnt;
    logic        r_we;
    logic [12:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wmask;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        w_accept;
    logic        w_req_err;

    assign w_accept  = req_valid_i && (r_state == c_IDLE);
    assign w_req_err = (req_addr_i[31:15] != BASE_ADDR[31:15]) || (req_addr_i[1:0] != 2'b00);

    assign sram_addr_o  = r_addr;
    assign sram_wdata_o = r_wdata;
    assign sram_wmask_o = r_wmask;
    assign rsp_rdata_o  = r_rdata;
    assign rsp_err_o    = r_err;

    always_comb begin
        w_state_nxt = r_state;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        sram_csb_o  = 1'b1;
        sram_we_o   = 1'b1;
        case (r_state)
            c_IDLE: begin
                req_ready_o = 1'b1;
                if (w_accept) w_state_nxt = w_req_err ? c_RESP : c_ACCESS;
            end
            c_ACCESS: begin
                sram_csb_o  = 1'b0;
                sram_we_o   = ~r_we;
                w_state_nxt = r_we ? c_RESP : c_WAIT;
            end
            c_WAIT: begin
                if (r_cnt == c_LAST) w_state_nxt = c_RESP;
            end
            c_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
            r_cnt   <= 3'd0;
            r_we    <= 1'b0;
            r_addr  <= 13'd0;
            r_wdata <= 32'd0;
            r_wmask <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_we    <= req_we_i;
                r_addr  <= req_addr_i[14:2];
                r_wdata <= req_wdata_i;
                r_wmask <= req_wmask_i;
                if (w_req_err) begin
                    r_rdata <= 32'd0;
                    r_err   <= 1'b1;
                end
            end
            if (r_state == c_ACCESS) begin
                r_cnt <= 3'd0;
                if (r_we) begin
                    r_rdata <= 32'd0;
                    r_err   <= 1'b0;
                end
            end
            // Read data is valid during the last WAIT cycle only.
            if (r_state == c_WAIT) begin
                if (r_cnt == c_LAST) begin
                    r_rdata <= sram_rdata_i;
                    r_err   <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 3'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_bus_bridge.sv
// ============================================================================
//  Module   : tb_sram_bus_bridge
//  Brief    : Directed and randomized checks of sram_bus_bridge with
//             READ_LAT=1 (instance a) and READ_LAT=3 (instance b).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sram_bus_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid_a, req_valid_b;
    logic [31:0] req_addr, req_wdata;
    logic        req_we;
    logic [3:0]  req_wmask;
    logic        rsp_ready;

    logic        req_ready_a, rsp_valid_a, rsp_err_a, csb_a, swe_a;
    logic [31:0] rsp_rdata_a, swdata_a, srdata_a;
    logic [12:0] saddr_a;
    logic [3:0]  swmask_a;

    logic        req_ready_b, rsp_valid_b, rsp_err_b, csb_b, swe_b;
    logic [31:0] rsp_rdata_b, swdata_b, srdata_b;
    logic [12:0] saddr_b;
    logic [3:0]  swmask_b;

    int n_tests = 0;
    int n_fail  = 0;
    int csb_cnt_a = 0;
    int csb_cnt_b = 0;

    logic [31:0] mem_a [8192];
    logic [31:0] mem_b [8192];
    logic [31:0] ref_b [8192];
    logic [31:0] pipe_b [3];

    sram_bus_bridge #(.BASE_ADDR(32'h0000_0000), .READ_LAT(1)) u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid_a), .req_ready_o(req_ready_a), .req_addr_i(req_addr),
        .req_we_i(req_we), .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
        .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_a),
        .rsp_err_o(rsp_err_a), .sram_csb_o(csb_a), .sram_we_o(swe_a), .sram_addr_o(saddr_a),
        .sram_wdata_o(swdata_a), .sram_wmask_o(swmask_a), .sram_rdata_i(srdata_a)
    );

    sram_bus_bridge #(.BASE_ADDR(32'h0000_0000), .READ_LAT(3)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid_b), .req_ready_o(req_ready_b), .req_addr_i(req_addr),
        .req_we_i(req_we), .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
        .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_b),
        .rsp_err_o(rsp_err_b), .sram_csb_o(csb_b), .sram_we_o(swe_b), .sram_addr_o(saddr_b),
        .sram_wdata_o(swdata_b), .sram_wmask_o(swmask_b), .sram_rdata_i(srdata_b)
    );

    // SRAM model a: one-cycle read latency, contents cleared by reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8192; i++) mem_a[i] <= 32'd0;
            srdata_a <= 32'd0;
        end else if (!csb_a) begin
            csb_cnt_a <= csb_cnt_a + 1;
            if (!swe_a) begin
                for (int i = 0; i < 4; i++)
                    if (swmask_a[i]) mem_a[saddr_a][i*8 +: 8] <= swdata_a[i*8 +: 8];
            end else begin
                srdata_a <= mem_a[saddr_a];
            end
        end
    end

    // SRAM model b: three-cycle read latency via a delay pipe.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8192; i++) mem_b[i] <= 32'd0;
            for (int i = 0; i < 3; i++) pipe_b[i] <= 32'd0;
        end else begin
            pipe_b[1] <= pipe_b[0];
            pipe_b[2] <= pipe_b[1];
            if (!csb_b) begin
                csb_cnt_b <= csb_cnt_b + 1;
                if (!swe_b) begin
                    for (int i = 0; i < 4; i++)
                        if (swmask_b[i]) mem_b[saddr_b][i*8 +: 8] <= swdata_b[i*8 +: 8];
                end else begin
                    pipe_b[0] <= mem_b[saddr_b];
                end
            end
        end
    end
    assign srdata_b = pipe_b[2];

    // Stimulus helper: called #1 after an edge with the selected bridge idle.
    task automatic txn(input bit sel, input logic [31:0] addr, input logic we,
                       input logic [31:0] wd, input logic [3:0] wm,
                       output logic [31:0] rd, output logic er, output int lat);
        req_addr = addr; req_we = we; req_wdata = wd; req_wmask = wm; rsp_ready = 1'b1;
        if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        lat = 1;
        while (!(sel ? rsp_valid_b : rsp_valid_a) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = sel ? rsp_rdata_b : rsp_rdata_a;
        er = sel ? rsp_err_b : rsp_err_a;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid_a = 1'b0; req_valid_b = 1'b0; rsp_ready = 1'b0;
        req_addr = 32'd0; req_we = 1'b0; req_wdata = 32'd0; req_wmask = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (csb_a !== 1'b1 || swe_a !== 1'b1) begin n_fail++; $display("FAIL rst_sram_ctl: got csb=%b we=%b exp 1 1", csb_a, swe_a); end
        n_tests++; if (saddr_a !== 13'd0 || swdata_a !== 32'd0 || swmask_a !== 4'd0) begin n_fail++; $display("FAIL rst_sram_bus: got addr=%h wdata=%h mask=%h exp 0", saddr_a, swdata_a, swmask_a); end
        n_tests++; if (rsp_valid_a !== 1'b0 || rsp_rdata_a !== 32'd0 || rsp_err_a !== 1'b0) begin n_fail++; $display("FAIL rst_rsp: got v=%b d=%h e=%b exp 0 0 0", rsp_valid_a, rsp_rdata_a, rsp_err_a); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (req_ready_a !== 1'b1 || req_ready_b !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got a=%b b=%b exp 1 1", req_ready_a, req_ready_b); end
    endtask

    task automatic test_write();
        req_addr = 32'h0000_0010; req_we = 1'b1; req_wdata = 32'hDEAD_BEEF; req_wmask = 4'hF;
        rsp_ready = 1'b1; req_valid_a = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        n_tests++; if (csb_a !== 1'b0 || swe_a !== 1'b0 || saddr_a !== 13'h004) begin n_fail++; $display("FAIL wr_access: got csb=%b we=%b addr=%h exp 0 0 004", csb_a, swe_a, saddr_a); end
        n_tests++; if (swdata_a !== 32'hDEAD_BEEF || swmask_a !== 4'hF) begin n_fail++; $display("FAIL wr_data: got %h/%h exp deadbeef/f", swdata_a, swmask_a); end
        n_tests++; if (rsp_valid_a !== 1'b0 || req_ready_a !== 1'b0) begin n_fail++; $display("FAIL wr_early: got v=%b rdy=%b exp 0 0", rsp_valid_a, req_ready_a); end
        @(posedge clk); #1;
        n_tests++; if (rsp_valid_a !== 1'b1 || rsp_err_a !== 1'b0 || rsp_rdata_a !== 32'd0 || csb_a !== 1'b1) begin n_fail++; $display("FAIL wr_rsp: got v=%b e=%b d=%h csb=%b exp 1 0 0 1", rsp_valid_a, rsp_err_a, rsp_rdata_a, csb_a); end
        @(posedge clk); #1;
        n_tests++; if (rsp_valid_a !== 1'b0 || req_ready_a !== 1'b1) begin n_fail++; $display("FAIL wr_done: got v=%b rdy=%b exp 0 1", rsp_valid_a, req_ready_a); end
    endtask

    task automatic test_read();
        req_addr = 32'h0000_0010; req_we = 1'b0; rsp_ready = 1'b1; req_valid_a = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        n_tests++; if (csb_a !== 1'b0 || swe_a !== 1'b1 || saddr_a !== 13'h004) begin n_fail++; $display("FAIL rd_access: got csb=%b we=%b addr=%h exp 0 1 004", csb_a, swe_a, saddr_a); end
        @(posedge clk); #1;
        n_tests++; if (rsp_valid_a !== 1'b0 || csb_a !== 1'b1) begin n_fail++; $display("FAIL rd_wait: got v=%b csb=%b exp 0 1", rsp_valid_a, csb_a); end
        @(posedge clk); #1;
        n_tests++; if (rsp_valid_a !== 1'b1 || rsp_rdata_a !== 32'hDEAD_BEEF || rsp_err_a !== 1'b0) begin n_fail++; $display("FAIL rd_rsp: got v=%b d=%h e=%b exp 1 deadbeef 0", rsp_valid_a, rsp_rdata_a, rsp_err_a); end
        @(posedge clk); #1;
    endtask

    task automatic test_error();
        logic [31:0] addrs [2];
        int c0;
        addrs[0] = 32'h0000_8000;
        addrs[1] = 32'h0000_0002;
        c0 = csb_cnt_a;
        for (int k = 0; k < 2; k++) begin
            req_addr = addrs[k]; req_we = 1'b0; rsp_ready = 1'b1; req_valid_a = 1'b1;
            @(posedge clk); #1;
            req_valid_a = 1'b0;
            n_tests++; if (rsp_valid_a !== 1'b1 || rsp_err_a !== 1'b1 || rsp_rdata_a !== 32'd0 || csb_a !== 1'b1) begin n_fail++; $display("FAIL err_rsp[%0d]: got v=%b e=%b d=%h csb=%b exp 1 1 0 1", k, rsp_valid_a, rsp_err_a, rsp_rdata_a, csb_a); end
            @(posedge clk); #1;
        end
        n_tests++; if (csb_cnt_a !== c0) begin n_fail++; $display("FAIL err_no_csb: got %0d pulses exp 0", csb_cnt_a - c0); end
    endtask

    task automatic test_backpressure();
        int c0;
        c0 = csb_cnt_a;
        req_addr = 32'h0000_0010; req_we = 1'b0; rsp_ready = 1'b0; req_valid_a = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 0; i < 5; i++) begin
            n_tests++; if (rsp_valid_a !== 1'b1 || rsp_rdata_a !== 32'hDEAD_BEEF || req_ready_a !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%b d=%h rdy=%b exp 1 deadbeef 0", i, rsp_valid_a, rsp_rdata_a, req_ready_a); end
            req_valid_a = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0040 + 32'(i * 4); req_wdata = 32'hFFFF_FFFF;
            @(posedge clk); #1;
        end
        req_valid_a = 1'b0;
        n_tests++; if (rsp_valid_a !== 1'b1 || req_ready_a !== 1'b0) begin n_fail++; $display("FAIL bp_still: got v=%b rdy=%b exp 1 0", rsp_valid_a, req_ready_a); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (rsp_valid_a !== 1'b0 || req_ready_a !== 1'b1) begin n_fail++; $display("FAIL bp_release: got v=%b rdy=%b exp 0 1", rsp_valid_a, req_ready_a); end
        n_tests++; if (csb_cnt_a - c0 !== 1) begin n_fail++; $display("FAIL bp_ignored: got %0d pulses exp 1", csb_cnt_a - c0); end
    endtask

    task automatic test_zero_mask();
        logic [31:0] rd;
        logic        er;
        int          lat, c0;
        c0 = csb_cnt_a;
        txn(1'b0, 32'h0000_0020, 1'b1, 32'h1234_5678, 4'h0, rd, er, lat);
        n_tests++; if (lat !== 2 || er !== 1'b0 || csb_cnt_a - c0 !== 1) begin n_fail++; $display("FAIL zmask_wr: got lat=%0d err=%b pulses=%0d exp 2 0 1", lat, er, csb_cnt_a - c0); end
        txn(1'b0, 32'h0000_0020, 1'b0, 32'd0, 4'h0, rd, er, lat);
        n_tests++; if (lat !== 3 || rd !== 32'd0 || er !== 1'b0) begin n_fail++; $display("FAIL zmask_rd: got lat=%0d d=%h e=%b exp 3 0 0", lat, rd, er); end
    endtask

    task automatic test_idle_ready();
        rsp_ready = 1'b1; req_valid_a = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_tests++; if (rsp_valid_a !== 1'b0 || req_ready_a !== 1'b1 || csb_a !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got v=%b rdy=%b csb=%b exp 0 1 1", rsp_valid_a, req_ready_a, csb_a); end
    endtask

    task automatic test_reset_mid();
        int nv;
        req_addr = 32'h0000_0010; req_we = 1'b0; rsp_ready = 1'b1; req_valid_a = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_tests++; if (csb_a !== 1'b1 || rsp_valid_a !== 1'b0 || req_ready_a !== 1'b1 || rsp_rdata_a !== 32'd0) begin n_fail++; $display("FAIL rstmid_state: got csb=%b v=%b rdy=%b d=%h exp 1 0 1 0", csb_a, rsp_valid_a, req_ready_a, rsp_rdata_a); end
        nv = 0;
        repeat (6) begin @(posedge clk); #1; if (rsp_valid_a) nv++; end
        n_tests++; if (nv !== 0) begin n_fail++; $display("FAIL rstmid_norsp: got %0d valid cycles exp 0", nv); end
    endtask

    task automatic test_random();
        logic [31:0] rd, wd;
        logic        er, we;
        logic [3:0]  wm;
        int          lat, idx, c0, bad;
        for (int i = 0; i < 8192; i++) ref_b[i] = 32'd0;
        c0 = csb_cnt_b;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            we  = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 15);
            wd  = $urandom;
            wm  = 4'($urandom_range(0, 15));
            txn(1'b1, 32'(idx) << 2, we, wd, wm, rd, er, lat);
            if (we) begin
                for (int b = 0; b < 4; b++) if (wm[b]) ref_b[idx][b*8 +: 8] = wd[b*8 +: 8];
                n_tests++; if (lat !== 2 || er !== 1'b0) begin n_fail++; $display("FAIL rnd_wr[%0d]: got lat=%0d err=%b exp 2 0", k, lat, er); end
            end else begin
                n_tests++; if (lat !== 5 || er !== 1'b0 || rd !== ref_b[idx]) begin n_fail++; $display("FAIL rnd_rd[%0d]: got lat=%0d err=%b d=%h exp 5 0 %h", k, lat, er, rd, ref_b[idx]); end
            end
        end
        n_tests++; if (csb_cnt_b - c0 !== 100) begin n_fail++; $display("FAIL rnd_csb: got %0d pulses exp 100", csb_cnt_b - c0); end
        bad = bad;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_error();
        test_backpressure();
        test_zero_mask();
        test_idle_ready();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
